// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch, holds the instruction for the
// decoder, and computes the next PC from branch/jump controls when it is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        addr_err,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: memory data is taken on a cycle with imem_req=1 and imem_ack=1;
  // the held instruction is consumed on a cycle with instr_valid=1 and instr_ready=1.

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_addr_err;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_taken;
  logic        w_consume;
  logic        w_misaligned;

  assign w_pc4        = r_pc + 32'd4;
  assign w_br_off     = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_taken      = (BranchEQ & Zero) | (BranchNE & ~Zero);
  assign w_consume    = (r_state == HOLD) && instr_ready;
  assign w_misaligned = (w_next_pc[1:0] != 2'b00);

  always_comb begin
    w_next_pc = w_pc4;
    if (JumpReg)
      w_next_pc = jr_target;
    else if (Jump)
      w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
    else if (w_taken)
      w_next_pc = w_pc4 + w_br_off;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:   if (imem_ack) w_next_state = HOLD;
      HOLD:    if (instr_ready) w_next_state = w_misaligned ? ERR : FETCH;
      ERR:     w_next_state = ERR;
      default: w_next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_retired  <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == FETCH) && imem_ack)
        r_instr <= imem_rdata;
      // A misaligned target retires the instruction but leaves pc on it.
      if (w_consume) begin
        r_retired <= r_retired + 32'd1;
        if (w_misaligned)
          r_addr_err <= 1'b1;
        else
          r_pc <= w_next_pc;
      end
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == HOLD);
  assign pc          = r_pc;
  assign retired     = r_retired;
  assign addr_err    = r_addr_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences plus a vector table of next-PC cases,
// with expected fetch addresses and instructions tracked through queues.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        BranchEQ, BranchNE, Jump, JumpReg, Zero;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        addr_err;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
    .Jump(Jump), .JumpReg(JumpReg), .Zero(Zero), .jr_target(jr_target),
    .pc(pc), .retired(retired), .addr_err(addr_err), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] tb_retired;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    instr_ready = 1'b0;
    BranchEQ = 1'b0; BranchNE = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Zero = 1'b0;
    jr_target = 32'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
  endtask

  // Reset asserted between edges; released on a falling edge.
  task automatic do_reset(input bit chk);
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    clear_ctrl();
    #3;
    if (chk) check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_instr_q.delete();
    exp_q.push_back(RESET_PC);
    tb_retired = 32'd0;
    tick();
  endtask

  // Pops the expected next fetch address and checks the live request.
  task automatic check_fetch_addr(input string tag);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_sb_empty: no expected address queued", tag);
    end else begin
      check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      check({tag, "_addr"}, imem_addr, exp_q.pop_front());
    end
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits);
    logic [31:0] a0;
    a0 = imem_addr;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr_stable", imem_addr, a0);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_instr_q.push_back(data);
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_instr", instr, exp_instr_q.pop_front());
  endtask

  task automatic do_consume(input logic beq, input logic bne, input logic j, input logic jr,
                            input logic z, input logic [31:0] tgt, input logic [31:0] exp_pc,
                            input logic exp_err, input int stalls);
    logic [31:0] pc0;
    pc0 = pc;
    for (int i = 0; i < stalls; i++) begin
      instr_ready = 1'b0;
      // Controls toggled while stalled must have no effect.
      BranchEQ = 1'($urandom_range(0, 1)); JumpReg = 1'($urandom_range(0, 1));
      jr_target = $urandom;
      tick();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", pc, pc0);
      check("stall_retired", retired, tb_retired);
    end
    instr_ready = 1'b1;
    BranchEQ = beq; BranchNE = bne; Jump = j; JumpReg = jr; Zero = z; jr_target = tgt;
    if (!exp_err) exp_q.push_back(exp_pc);
    tb_retired = tb_retired + 32'd1;
    tick();
    clear_ctrl();
    check("consume_retired", retired, tb_retired);
    if (exp_err) begin
      check("err_flag", {31'd0, addr_err}, 32'd1);
      check("err_pc", pc, pc0);
      check("err_req", {31'd0, imem_req}, 32'd0);
      check("err_valid", {31'd0, instr_valid}, 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [31:0] ins;
    logic        beq, bne, j, jr, z;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic set_v(input int i, input string n, input logic [31:0] sp, input logic [31:0] ins,
                       input logic beq, input logic bne, input logic j, input logic jr,
                       input logic z, input logic [31:0] tgt, input logic [31:0] ep,
                       input logic ee);
    vecs[i].name = n; vecs[i].start_pc = sp; vecs[i].ins = ins;
    vecs[i].beq = beq; vecs[i].bne = bne; vecs[i].j = j; vecs[i].jr = jr; vecs[i].z = z;
    vecs[i].tgt = tgt; vecs[i].exp_pc = ep; vecs[i].exp_err = ee;
  endtask

  initial begin
    //          name        start         instr         beq bne j  jr z  jr_target     exp_pc        err
    set_v(0,  "beq_self",   32'h0040_0010, 32'h1000_FFFF, 1, 0, 0, 0, 1, 32'h0,        32'h0040_0010, 0);
    set_v(1,  "bne_nt",     32'h0040_0010, 32'h1400_FFFF, 0, 1, 0, 0, 1, 32'h0,        32'h0040_0014, 0);
    set_v(2,  "jump",       32'h0040_0008, 32'h0810_0003, 0, 0, 1, 0, 0, 32'h0,        32'h0040_000C, 0);
    set_v(3,  "jr_over_j",  32'h0040_0008, 32'h0810_0003, 0, 0, 1, 1, 0, 32'h0040_0100, 32'h0040_0100, 0);
    set_v(4,  "both_br",    32'h0040_0020, 32'h1000_0002, 1, 1, 0, 0, 0, 32'h0,        32'h0040_002C, 0);
    set_v(5,  "beq_nt",     32'h0040_0020, 32'h1000_0010, 1, 0, 0, 0, 0, 32'h0,        32'h0040_0024, 0);
    set_v(6,  "seq_wrap",   32'hFFFF_FFFC, 32'h2008_0005, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0000, 0);
    set_v(7,  "br_wrap",    32'h0000_0000, 32'h1400_FFFE, 0, 1, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0);
    set_v(8,  "bne_fwd",    32'h0040_0000, 32'h1400_0004, 0, 1, 0, 0, 0, 32'h0,        32'h0040_0014, 0);
    set_v(9,  "j_over_br",  32'h0040_0000, 32'h0800_0004, 1, 0, 1, 0, 1, 32'h0,        32'h0000_0010, 0);
    set_v(10, "j_hi_bits",  32'hF000_0000, 32'h0BFF_FFFF, 0, 0, 1, 0, 0, 32'h0,        32'hFFFF_FFFC, 0);
    set_v(11, "jr_misalign",32'h0040_0010, 32'h0000_0008, 0, 0, 0, 1, 0, 32'h0040_0102, 32'h0,        1);
  end

  // ---------------- test ----------------
  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    clear_ctrl();
    #1;

    // Sequential flow from reset.
    do_reset(1'b1);
    check_fetch_addr("first_fetch");
    do_fetch(32'h2008_0005, 0);
    do_consume(0, 0, 0, 0, 0, 32'h0, 32'h0040_0004, 0, 0);
    check_fetch_addr("seq_next");

    // Wait states then backpressure.
    do_fetch(32'h0000_0000 | $urandom_range(0, 32'hFFFF), 3);
    do_consume(0, 0, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 4);
    check_fetch_addr("bp_next");

    // Next-PC vector table; each case reaches its start PC through a JumpReg.
    for (int i = 0; i < 12; i++) begin
      do_reset(1'b0);
      check_fetch_addr({vecs[i].name, "_rst"});
      do_fetch(32'h0000_0008, $urandom_range(0, 2));
      do_consume(0, 0, 0, 1, 0, vecs[i].start_pc, vecs[i].start_pc, 0, 0);
      check_fetch_addr({vecs[i].name, "_start"});
      do_fetch(vecs[i].ins, $urandom_range(0, 2));
      do_consume(vecs[i].beq, vecs[i].bne, vecs[i].j, vecs[i].jr, vecs[i].z,
                 vecs[i].tgt, vecs[i].exp_pc, vecs[i].exp_err, $urandom_range(0, 2));
      if (!vecs[i].exp_err) check_fetch_addr({vecs[i].name, "_next"});
    end

    // ERR is terminal: inputs are ignored.
    imem_ack = 1'b1; instr_ready = 1'b1; JumpReg = 1'b1; jr_target = 32'h0040_0200;
    repeat (3) tick();
    imem_ack = 1'b0; clear_ctrl();
    check("err_stuck_state", {30'd0, dbg_state}, 32'd2);
    check("err_stuck_req", {31'd0, imem_req}, 32'd0);
    check("err_stuck_retired", retired, tb_retired);
    check("err_stuck_pc", pc, 32'h0040_0010);

    // Reset mid-fetch at 0x0040_0020, then a late ack after release.
    do_reset(1'b0);
    check_fetch_addr("mid_rst");
    do_fetch(32'h0000_0008, 0);
    do_consume(0, 0, 0, 1, 0, 32'h0040_0020, 32'h0040_0020, 0, 0);
    check_fetch_addr("mid_pending");
    reset = 1'b1;
    #2;
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b0;
    tb_retired = 32'd0;
    exp_q.push_back(RESET_PC);
    tick();
    check_fetch_addr("mid_after");
    do_fetch(32'h1234_5678, 0);
    check("late_ack_pc", pc, RESET_PC);
    check("late_ack_retired", retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, which is the first instruction address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit, instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits, instruction memory byte address (equals PC).
REQ-006 The block SHALL have port imem_ack, input, 1 bit, memory data valid this cycle; ignored unless imem_req=1.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits, fetched instruction word, sampled when imem_req=1 and imem_ack=1.
REQ-008 The block SHALL have port instr, output, 32 bits, held instruction presented to the decoder (OP = instr[31:26]).
REQ-009 The block SHALL have port instr_valid, output, 1 bit, instr holds a fetched, unconsumed instruction.
REQ-010 The block SHALL have port instr_ready, input, 1 bit, decoder/execute consumes instr this cycle.
REQ-011 The block SHALL have ports BranchEQ, BranchNE, Jump, JumpReg, and Zero, each input, 1 bit, control and ALU results for the instruction being consumed.
REQ-012 The block SHALL have port jr_target, input, 32 bits, register-sourced target for JumpReg.
REQ-013 The block SHALL have port pc, output, 32 bits, address of the instruction in instr or being fetched.
REQ-014 The block SHALL have port retired, output, 32 bits, count of consumed instructions.
REQ-015 The block SHALL have port addr_err, output, 1 bit, sticky misaligned-target flag.

Function
REQ-016 The FSM SHALL have states FETCH, HOLD and ERR.
REQ-017 In FETCH: imem_req=1, imem_addr=pc, instr_valid=0; on imem_ack=1, instr<=imem_rdata and the state goes to HOLD; with imem_ack=0 the state stays in FETCH, so any number of wait states are tolerated.
REQ-018 In HOLD: imem_req=0, instr_valid=1, and instr and pc are stable; with instr_ready=0 the state stays in HOLD indefinitely.
REQ-019 In HOLD with instr_ready=1, the block SHALL sample the control inputs at that edge, load pc<=next_pc, increment retired, and go to FETCH (or ERR per REQ-022).
REQ-020 next_pc SHALL be pc4=pc+4 by default; if branch taken, pc4 + (sign-extended instr[15:0] << 2); if Jump, {pc4[31:28], instr[25:0], 2'b00}; if JumpReg, jr_target; precedence is JumpReg > Jump > branch > sequential.
REQ-021 Branch taken SHALL be (BranchEQ & Zero) | (BranchNE & ~Zero); if both BranchEQ and BranchNE are 1, the branch is always taken.
REQ-022 If next_pc[1:0] != 0 at consume, the block SHALL keep pc unchanged, still increment retired, set addr_err=1, and enter ERR.
REQ-023 In ERR: imem_req=0 and instr_valid=0; the block remains in ERR until reset, and all inputs are ignored.
REQ-024 All address arithmetic SHALL be 32-bit modulo 2^32: pc=32'hFFFF_FFFC sequential wraps to 0, and backward branches below 0 wrap.
REQ-025 retired SHALL wrap from 32'hFFFF_FFFF to 0 without a flag.
REQ-026 At most one instruction SHALL be outstanding; imem_req is never asserted in HOLD, so a fetch is never issued before the previous instr is consumed.
REQ-027 Control inputs SHALL be ignored outside HOLD or when instr_ready=0.

Reset
REQ-028 While reset=1 (asynchronous, any time): state=FETCH, pc=RESET_PC, instr=0, retired=0, addr_err=0, instr_valid=0.
REQ-029 Reset asserted during a pending fetch or in HOLD SHALL abandon the fetch or held instruction; a late imem_ack after reset deassertion is treated as an ack for RESET_PC.
REQ-030 On the first edge after reset deasserts, the block SHALL issue imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 Sequential flow: after reset, ack immediately with rdata=32'h2008_0005, then instr_ready=1 with no control inputs set -> instr=32'h2008_0005, next fetch at 32'h0040_0004, retired=1.
REQ-032 Wait states and backpressure: hold imem_ack=0 for 3 cycles, then hold instr_ready=0 for 4 cycles -> imem_addr stable during the waits, instr_valid stays 1, and pc/retired are unchanged until consume.
REQ-033 Branches: beq with instr[15:0]=16'hFFFF and Zero=1 at pc=32'h0040_0010 -> next pc=32'h0040_0010; bne with Zero=1 -> 32'h0040_0014.
REQ-034 Jump precedence: instr=32'h0810_0003 with Jump=1 at pc=32'h0040_0008 -> next pc=32'h0040_000C; JumpReg=1 with Jump=1 and jr_target=32'h0040_0100 -> next pc=32'h0040_0100.
REQ-035 Misalignment: JumpReg=1 with jr_target=32'h0040_0102 -> addr_err=1, state ERR, imem_req=0, retired incremented, and pc unchanged.
REQ-036 Reset mid-fetch: assert reset while imem_req=1 at pc=32'h0040_0020 -> outputs immediately take their reset values, with the next fetch at 32'h0040_0000.
